// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single RegFile write port between the in-order
// WB stage and a multi-cycle execution unit.
// - The WB stage always wins. Multi-cycle results wait in a small FIFO and
//   drain into free write slots, oldest first.
// - A 32-entry scoreboard of pending destinations stalls ID on RAW/WAW hazards.
// - A starvation counter forces ID bubbles when the FIFO head is blocked too
//   long, so that a free slot eventually reaches WB.
// Optional feature: define WB_BYPASS_EN to let a result write straight through
// to the RegFile, with zero latency, when the FIFO is empty and the WB slot is free.
module wb_port_arbiter #(
    parameter int XLEN         = 32,  // keep in step with riscv_pkg::XLEN
    parameter int DEPTH        = 2,   // power of two, >= 2
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pipe_reg_write,
    input  logic [4:0]      pipe_rd,
    input  logic [XLEN-1:0] pipe_data,
    input  logic            mc_issue_valid,
    input  logic [4:0]      mc_issue_rd,
    input  logic            mc_valid,
    output logic            mc_ready,
    input  logic [4:0]      mc_rd,
    input  logic [XLEN-1:0] mc_data,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    output logic            stall_id,
    output logic            rf_reg_write,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_write_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } mc_entry_t;

    mc_entry_t       mem [DEPTH];
    mc_entry_t       head;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [SW-1:0]   starve_cnt;
    logic [31:0]     sb;
    logic [31:0]     sb_next;

    logic pipe_busy;
    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push;
    logic bypass;
    logic drain_force;

    assign pipe_busy   = pipe_reg_write && (pipe_rd != 5'd0);
    assign fifo_empty  = (count == '0);
    assign fifo_full   = (count == FULL_CNT);
    assign head        = mem[rd_ptr];
    assign pop         = !rst && !pipe_busy && !fifo_empty;
    assign drain_force = (starve_cnt == STARVE_MAX);

`ifdef WB_BYPASS_EN
    assign bypass = !rst && mc_valid && fifo_empty && !pipe_busy;
`else
    assign bypass = 1'b0;
`endif

    // Ready depends on fullness only; a bypassed result is accepted but not stored.
    assign mc_ready = !rst && !fifo_full;
    assign push     = !rst && mc_valid && !fifo_full && !bypass;

    // Write-port mux: pipe first, then FIFO head, then (optionally) the bypass.
    always_comb begin
        // NOTE: every output gets a default before the priority chain, so no path leaves one unassigned and no latch is inferred.
        rf_reg_write  = 1'b0;
        rf_rd         = 5'd0;
        rf_write_data = '0;
        if (!rst) begin
            if (pipe_busy) begin
                rf_reg_write  = 1'b1;
                rf_rd         = pipe_rd;
                rf_write_data = pipe_data;
            end else if (!fifo_empty) begin
                rf_reg_write  = (head.rd != 5'd0);
                rf_rd         = head.rd;
                rf_write_data = head.data;
            end else if (bypass) begin
                rf_reg_write  = (mc_rd != 5'd0);
                rf_rd         = mc_rd;
                rf_write_data = mc_data;
            end
        end
    end

    // Scoreboard next state: retire clears first, so a same-cycle issue wins.
    always_comb begin
        sb_next = sb;
        if (pop) begin
            sb_next[head.rd] = 1'b0;
        end
        if (bypass) begin
            sb_next[mc_rd] = 1'b0;
        end
        if (!rst && mc_issue_valid) begin
            sb_next[mc_issue_rd] = 1'b1;
        end
        sb_next[0] = 1'b0;
    end

    // ID stall on pending source/destination registers or a forced drain.
    assign stall_id = !rst && (((id_rs1 != 5'd0) && sb[id_rs1]) ||
                               ((id_rs2 != 5'd0) && sb[id_rs2]) ||
                               ((id_rd  != 5'd0) && sb[id_rd])  ||
                               drain_force);

    // FIFO storage: written on push only.
    // NOTE: the data array has no reset; validity is carried entirely by count, so clearing it would only cost flops.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{rd: mc_rd, data: mc_data};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb <= '0;
        end else begin
            sb <= sb_next;
        end
    end

    // Starvation counter: counts blocked head cycles, saturating at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (fifo_empty || pop) begin
            starve_cnt <= '0;
        end else if (!drain_force) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: directed scenarios with literal expectations,
// plus a queue-based reference model compared on every falling clock edge.
module tb_wb_port_arbiter;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic            clk;
    logic            rst;
    logic            pipe_reg_write;
    logic [4:0]      pipe_rd;
    logic [XLEN-1:0] pipe_data;
    logic            mc_issue_valid;
    logic [4:0]      mc_issue_rd;
    logic            mc_valid;
    logic            mc_ready;
    logic [4:0]      mc_rd;
    logic [XLEN-1:0] mc_data;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic            stall_id;
    logic            rf_reg_write;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_write_data;

    wb_port_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .pipe_reg_write(pipe_reg_write), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .mc_issue_valid(mc_issue_valid), .mc_issue_rd(mc_issue_rd),
        .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_rd(mc_rd), .mc_data(mc_data),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .stall_id(stall_id),
        .rf_reg_write(rf_reg_write), .rf_rd(rf_rd), .rf_write_data(rf_write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } res_t;

    res_t      mq[$];
    bit [31:0] m_sb = '0;
    int        m_starve = 0;

    bit        d_valid = 0;
    bit        d_pop, d_push;
    res_t      d_item;
    bit [31:0] d_sb;
    int        d_starve;

    always @(negedge clk) begin : compare
        bit              busy;
        bit              byp;
        bit              exp_we;
        logic [4:0]      exp_rd;
        logic [XLEN-1:0] exp_data;
        bit              exp_stall;
        bit [31:0]       nsb;
        if (rst) begin
            check("rst_mc_ready", mc_ready, 0);
            check("rst_stall_id", stall_id, 0);
            check("rst_rf_we", rf_reg_write, 0);
            check("rst_rf_rd", rf_rd, 0);
            check("rst_rf_data", rf_write_data, 0);
            d_valid = 0;
        end else begin
            busy = pipe_reg_write && (pipe_rd != 0);
            byp  = 0;
`ifdef WB_BYPASS_EN
            byp = mc_valid && (mq.size() == 0) && !busy;
`endif
            exp_we = 0; exp_rd = 0; exp_data = 0;
            if (busy) begin
                exp_we = 1; exp_rd = pipe_rd; exp_data = pipe_data;
            end else if (mq.size() != 0) begin
                exp_we = (mq[0].rd != 0); exp_rd = mq[0].rd; exp_data = mq[0].data;
            end else if (byp) begin
                exp_we = (mc_rd != 0); exp_rd = mc_rd; exp_data = mc_data;
            end
            exp_stall = (m_starve == LIMIT) ||
                        (id_rs1 != 0 && m_sb[id_rs1]) ||
                        (id_rs2 != 0 && m_sb[id_rs2]) ||
                        (id_rd  != 0 && m_sb[id_rd]);
            check("mdl_mc_ready", mc_ready, mq.size() < DEPTH);
            check("mdl_stall_id", stall_id, exp_stall);
            check("mdl_rf_we", rf_reg_write, exp_we);
            if (exp_we) begin
                check("mdl_rf_rd", rf_rd, exp_rd);
                check("mdl_rf_data", rf_write_data, exp_data);
            end
            // decide what the coming edge does
            d_pop  = !busy && (mq.size() != 0);
            d_push = mc_valid && (mq.size() < DEPTH) && !byp;
            d_item = '{rd: mc_rd, data: mc_data};
            nsb = m_sb;
            if (d_pop) nsb[mq[0].rd] = 0;
            if (byp) nsb[mc_rd] = 0;
            if (mc_issue_valid) nsb[mc_issue_rd] = 1;
            nsb[0] = 0;
            d_sb = nsb;
            if (mq.size() != 0 && busy) d_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
            else d_starve = 0;
            d_valid = 1;
        end
    end

    always @(posedge clk or posedge rst) begin : model_update
        if (rst) begin
            mq.delete();
            m_sb     <= '0;
            m_starve <= 0;
            d_valid  <= 0;
        end else if (d_valid) begin
            if (d_pop) void'(mq.pop_front());
            if (d_push) mq.push_back(d_item);
            m_sb     <= d_sb;
            m_starve <= d_starve;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pipe_reg_write = 0; pipe_rd = 0; pipe_data = 0;
        mc_issue_valid = 0; mc_issue_rd = 0;
        mc_valid = 0; mc_rd = 0; mc_data = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    endtask

    initial begin
        rst = 1;
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("t0_ready_after_release", mc_ready, 1);

        // 1: reset pulsed asynchronously during a push of rd=5
        tick(); mc_issue_valid = 1; mc_issue_rd = 5;
        tick(); mc_issue_valid = 0;
        mc_valid = 1; mc_rd = 5; mc_data = 32'h55;
        pipe_reg_write = 1; pipe_rd = 3; pipe_data = 32'h33; id_rs1 = 5;
        @(negedge clk);
        check("t1_stall_rs1_5", stall_id, 1);
        check("t1_ready_pre", mc_ready, 1);
        #2 rst = 1;
        #1;
        check("t1_rst_ready", mc_ready, 0);
        check("t1_rst_stall", stall_id, 0);
        check("t1_rst_we", rf_reg_write, 0);
        check("t1_rst_rd", rf_rd, 0);
        check("t1_rst_data", rf_write_data, 0);
        @(posedge clk); #1;
        idle(); id_rs1 = 5; rst = 0;
        @(negedge clk);
        check("t1_ready_after", mc_ready, 1);
        check("t1_sb5_cleared", stall_id, 0);
        check("t1_fifo_empty", rf_reg_write, 0);

        // 2: issue rd=7, RAW stall until the result retires
        tick(); idle(); mc_issue_valid = 1; mc_issue_rd = 7;
        tick(); mc_issue_valid = 0; id_rs1 = 7;
        @(negedge clk); check("t2_stall_after_issue", stall_id, 1);
        tick(); mc_valid = 1; mc_rd = 7; mc_data = 32'hDEADBEEF;
        @(negedge clk);
        check("t2_stall_arrive", stall_id, 1);
`ifdef WB_BYPASS_EN
        check("t2_byp_we", rf_reg_write, 1);
        check("t2_byp_rd", rf_rd, 7);
        check("t2_byp_data", rf_write_data, 32'hDEADBEEF);
`else
        check("t2_no_write_yet", rf_reg_write, 0);
`endif
        tick(); mc_valid = 0;
        @(negedge clk);
`ifdef WB_BYPASS_EN
        check("t2_byp_stall_off", stall_id, 0);
`else
        check("t2_we", rf_reg_write, 1);
        check("t2_rd", rf_rd, 7);
        check("t2_data", rf_write_data, 32'hDEADBEEF);
        check("t2_stall_during_write", stall_id, 1);
`endif
        tick();
        @(negedge clk);
        check("t2_stall_off", stall_id, 0);
        check("t2_idle_we", rf_reg_write, 0);

        // 3: starvation of rd=9 behind continuous x3 writes
        tick(); idle(); mc_issue_valid = 1; mc_issue_rd = 9;
        pipe_reg_write = 1; pipe_rd = 3; pipe_data = 32'h33;
        tick(); mc_issue_valid = 0; mc_valid = 1; mc_rd = 9; mc_data = 32'h99;
        @(negedge clk); check("t3_pipe_rd", rf_rd, 3); check("t3_stall0", stall_id, 0);
        tick(); mc_valid = 0;
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge clk);
            check("t3_blocked_rd", rf_rd, 3);
            check("t3_blocked_stall", stall_id, 0);
            tick();
        end
        @(negedge clk); check("t3_drain_force", stall_id, 1); check("t3_rd_still3", rf_rd, 3);
        tick();
        @(negedge clk); check("t3_force_held", stall_id, 1);
        tick(); pipe_reg_write = 0;
        @(negedge clk);
        check("t3_drain_we", rf_reg_write, 1);
        check("t3_drain_rd", rf_rd, 9);
        check("t3_drain_data", rf_write_data, 32'h99);
        check("t3_stall_until_pop", stall_id, 1);
        tick();
        @(negedge clk); check("t3_stall_off", stall_id, 0); check("t3_we_off", rf_reg_write, 0);

        // 4: fill the FIFO while the pipe owns the port, then drain in order
        tick(); idle(); pipe_reg_write = 1; pipe_rd = 3; pipe_data = 32'h33;
        mc_valid = 1; mc_rd = 10; mc_data = 32'hA0;
        @(negedge clk); check("t4_ready_e0", mc_ready, 1);
        tick(); mc_rd = 11; mc_data = 32'hB1;
        @(negedge clk); check("t4_ready_e1", mc_ready, 1);
        tick(); mc_rd = 13; mc_data = 32'hC3;
        @(negedge clk); check("t4_full", mc_ready, 0);
        tick(); pipe_reg_write = 0;
        @(negedge clk);
        check("t4_full_still", mc_ready, 0);
        check("t4_pop1_rd", rf_rd, 10);
        check("t4_pop1_data", rf_write_data, 32'hA0);
        tick();
        @(negedge clk); check("t4_ready_after_pop", mc_ready, 1); check("t4_pop2_rd", rf_rd, 11);
        tick(); mc_valid = 0;
        @(negedge clk); check("t4_pop3_rd", rf_rd, 13); check("t4_pop3_data", rf_write_data, 32'hC3);
        tick();
        @(negedge clk); check("t4_empty_we", rf_reg_write, 0);

        // 5: re-issue of rd=4 in the same cycle its older result pops
        tick(); idle(); mc_issue_valid = 1; mc_issue_rd = 4;
        tick(); mc_issue_valid = 0; mc_valid = 1; mc_rd = 4; mc_data = 32'h44;
        pipe_reg_write = 1; pipe_rd = 3;
        tick(); mc_valid = 0; pipe_reg_write = 0;
        mc_issue_valid = 1; mc_issue_rd = 4; id_rs2 = 4;
        @(negedge clk); check("t5_pop_rd", rf_rd, 4); check("t5_stall", stall_id, 1);
        tick(); mc_issue_valid = 0;
        @(negedge clk); check("t5_set_wins", stall_id, 1);
        tick(); mc_valid = 1; mc_rd = 4; mc_data = 32'h45;
        tick(); mc_valid = 0;
        tick();
        @(negedge clk); check("t5_stall_off", stall_id, 0);

        // 6: result to x0 pops silently; bypass of rd=12 when enabled
        tick(); idle(); mc_issue_valid = 1; mc_issue_rd = 6;
        tick(); mc_issue_valid = 0; id_rs1 = 6; mc_valid = 1; mc_rd = 0; mc_data = 32'h5;
        @(negedge clk); check("t6_x0_we_a", rf_reg_write, 0); check("t6_stall_a", stall_id, 1);
        tick(); mc_valid = 0;
        @(negedge clk); check("t6_x0_we_b", rf_reg_write, 0); check("t6_sb_kept", stall_id, 1);
        tick();
        @(negedge clk); check("t6_ready", mc_ready, 1); check("t6_we_c", rf_reg_write, 0);
        tick(); mc_valid = 1; mc_rd = 6; mc_data = 32'h66;
        tick(); mc_valid = 0;
        repeat (2) tick();
        idle(); mc_valid = 1; mc_rd = 12; mc_data = 32'h1;
        @(negedge clk);
`ifdef WB_BYPASS_EN
        check("t6_byp_we", rf_reg_write, 1);
        check("t6_byp_rd", rf_rd, 12);
        check("t6_byp_data", rf_write_data, 32'h1);
        check("t6_byp_ready", mc_ready, 1);
`else
        check("t6_fifo_we", rf_reg_write, 0);
        check("t6_fifo_ready", mc_ready, 1);
`endif
        tick(); mc_valid = 0;
        @(negedge clk);
`ifdef WB_BYPASS_EN
        check("t6_byp_nothing_queued", rf_reg_write, 0);
`else
        check("t6_fifo_we2", rf_reg_write, 1);
        check("t6_fifo_rd2", rf_rd, 12);
        check("t6_fifo_data2", rf_write_data, 32'h1);
`endif
        tick();
        @(negedge clk); check("t6_final_idle", rf_reg_write, 0);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
